// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter: launches one byte per tx_start pulse
// and holds off the next launch until the transmitter reports tx_done_tick.
module uart_tx_buffer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DBIT   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_accept;
  logic              pop;

  // Flags and launch pulse decode straight from registered state.
  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign busy      = (state == ST_WAIT);
  assign tx_start  = (state == ST_IDLE) && !empty;
  assign tx_data   = mem[rd_ptr];
  assign wr_accept = wr_en && !full;
  assign pop       = tx_start;

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // A pop in the same cycle does not rescue a write seen against full.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Launch controller: one launch, then wait for the frame to finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!empty)      state <= ST_WAIT;
        ST_WAIT: if (tx_done_tick) state <= ST_IDLE;
        default:                  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a simple transmitter model that
// returns tx_done_tick a fixed number of cycles after each launch.
module tb_uart_tx_buffer;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DBIT   = 8;
  localparam int FRAME = 160;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [DBIT-1:0]   wr_data = '0;
  logic              tx_done_tick;
  logic              tx_start;
  logic [DBIT-1:0]   tx_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  // Transmitter model state.
  logic       model_done = 1'b0;
  logic       force_done = 1'b0;
  bit         auto_done = 1'b1;
  bit         pending = 1'b0;
  int         timer = 0;
  int         cyc = 0;
  logic [7:0] got[$];
  int         start_cyc[$];
  int         done_cyc[$];

  assign tx_done_tick = model_done | force_done;

  uart_tx_buffer #(.ADDR_W(ADDR_W), .DBIT(DBIT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
    .full(full), .empty(empty), .count(count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Capture launches mid-cycle and schedule the end-of-frame pulse.
  always @(negedge clk) begin
    cyc++;
    model_done = 1'b0;
    if (reset) begin
      pending = 1'b0;
      timer = 0;
    end else if (force_done) begin
      pending = 1'b0;
    end else if (tx_start) begin
      got.push_back(tx_data);
      start_cyc.push_back(cyc);
      timer = FRAME;
      pending = 1'b1;
    end else if (pending) begin
      if (timer > 0) timer--;
      if (timer == 0 && auto_done) begin
        model_done = 1'b1;
        pending = 1'b0;
        done_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    int k = 0;
    while ((got.size() < n || busy || !empty) && k < 20000) begin
      tick();
      k++;
    end
    check(tag, 32'(got.size()), 32'(n));
  endtask

  task automatic clear_log();
    got.delete();
    start_cyc.delete();
    done_cyc.delete();
  endtask

  initial begin
    int k;
    int idx;
    int exp_cnt[4] = '{1, 1, 2, 3};

    // Reset state
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Single byte launch and busy window
    clear_log();
    write_byte(8'hA5);
    check("t1_start", 32'(tx_start), 1);
    check("t1_data", 32'(tx_data), 32'h A5);
    check("t1_count1", 32'(count), 1);
    tick();
    check("t1_start_low", 32'(tx_start), 0);
    check("t1_count0", 32'(count), 0);
    check("t1_empty", 32'(empty), 1);
    check("t1_busy", 32'(busy), 1);
    k = 0;
    while (busy && k < 1000) begin
      tick();
      k++;
    end
    check("t1_busy_len", 32'(k), 32'(FRAME));
    check("t1_launches", 32'(got.size()), 1);
    check("t1_byte", 32'(got[0]), 32'h A5);

    // Burst of four: ordering, counts, one-cycle inter-frame gap
    clear_log();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h11 + i);
      tick();
      check("t2_count", 32'(count), 32'(exp_cnt[i]));
    end
    wr_en = 1'b0;
    drain("t2_launches", 4);
    for (int i = 0; i < 4; i++) check("t2_byte", 32'(got[i]), 32'(8'h11 + i));
    for (int i = 0; i < 3; i++) check("t2_gap", 32'(start_cyc[i+1]), 32'(done_cyc[i] + 1));
    check("t2_count_end", 32'(count), 0);

    // Fill to full while the transmitter is held busy, then overflow
    auto_done = 1'b0;
    write_byte(8'hEE);
    tick();
    check("t3_busy", 32'(busy), 1);
    clear_log();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
      if (i == 15) begin
        check("t3_full16", 32'(full), 1);
        check("t3_count16", 32'(count), 16);
        check("t3_no_ovf_yet", 32'(overflow), 0);
      end
    end
    wr_en = 1'b0;
    check("t3_overflow", 32'(overflow), 1);
    check("t3_count_hold", 32'(count), 16);

    // tx_done_tick and a write against full in the same cycle
    force_done = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h55;
    tick();
    force_done = 1'b0;
    wr_en = 1'b0;
    check("t4_overflow", 32'(overflow), 1);
    check("t4_count", 32'(count), 16);
    check("t4_start", 32'(tx_start), 1);
    check("t4_head", 32'(tx_data), 32'h00);
    tick();
    check("t4_count15", 32'(count), 15);
    check("t4_busy", 32'(busy), 1);
    auto_done = 1'b1;
    drain("t3_launches", 16);
    for (int i = 0; i < 16; i++) check("t3_byte", 32'(got[i]), 32'(i));

    // Reset mid-frame with five bytes queued
    auto_done = 1'b0;
    clear_log();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h60 + i);
      tick();
    end
    wr_en = 1'b0;
    check("t6_count5", 32'(count), 5);
    check("t6_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    tick();
    check("t6_count", 32'(count), 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_busy0", 32'(busy), 0);
    check("t6_start0", 32'(tx_start), 0);
    check("t6_overflow0", 32'(overflow), 0);
    reset = 1'b0;
    auto_done = 1'b1;
    clear_log();
    write_byte(8'h3C);
    check("t6_start", 32'(tx_start), 1);
    check("t6_data", 32'(tx_data), 32'h3C);
    drain("t6_launches", 1);
    check("t6_byte", 32'(got[0]), 32'h3C);

    // Streaming 40 bytes through the wrapping pointers
    clear_log();
    idx = 0;
    k = 0;
    while (idx < 40 && k < 20000) begin
      if (!full) begin
        wr_en = 1'b1;
        wr_data = 8'(idx);
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      k++;
    end
    wr_en = 1'b0;
    check("t5_written", 32'(idx), 40);
    drain("t5_launches", 40);
    for (int i = 0; i < 40; i++) check("t5_byte", 32'(got[i]), 32'(i));
    check("t5_overflow", 32'(overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
